pmu_reg_bridge: RTL

PMU_REG_BRIDGE -- requirements
Module: pmu_reg_bridge

---
 rtl/pmu_reg_bridge.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pmu_reg_bridge.sv
// pmu_reg_bridge: request/grant register bus in front of a PMU raw register bank.
// Writes read-modify-write a shadow array then pulse a bulk strobe. Define PMU_BRIDGE_BE_EN for byte enables.
module pmu_reg_bridge #(
  parameter int REG_WIDTH  = 32,
  parameter int N_REGS     = 43,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_i,
  input  logic                                 we_i,
  input  logic [ADDR_WIDTH-1:0]                addr_i,
  input  logic [REG_WIDTH-1:0]                 wdata_i,
  input  logic [REG_WIDTH/8-1:0]               be_i,
  output logic                                 gnt_o,
  output logic                                 rvalid_o,
  output logic [REG_WIDTH-1:0]                 rdata_o,
  output logic                                 err_o,
  input  logic [N_REGS-1:0][REG_WIDTH-1:0]     regs_i,
  output logic [N_REGS-1:0][REG_WIDTH-1:0]     regs_o,
  output logic                                 wrapper_we_o
);
  localparam int NB = REG_WIDTH / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MERGE  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]                          r_state;
  logic [ADDR_WIDTH-1:0]               r_addr;
  logic [REG_WIDTH-1:0]                r_wdata;
  logic [N_REGS-1:0][REG_WIDTH-1:0]    r_shadow;
  logic [REG_WIDTH-1:0]                r_rdata;
  logic                                r_rvalid;
  logic                                r_err;
  logic                                r_we;

  logic                                w_accept;
  logic                                w_in_range;
  logic [REG_WIDTH-1:0]                w_rd_word;
  logic [REG_WIDTH-1:0]                w_merged;

  assign gnt_o      = (r_state == IDLE) && !rst_i;
  assign w_accept   = req_i && gnt_o;
  assign w_in_range = (32'(addr_i) < 32'(N_REGS));

  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (addr_i == ADDR_WIDTH'(k)) w_rd_word = regs_i[k];
    end
  end

`ifdef PMU_BRIDGE_BE_EN
  logic [NB-1:0]        r_be;
  logic [REG_WIDTH-1:0] w_cur_word;

  // Live value of the target register, sampled in MERGE for the byte merge.
  always_comb begin
    w_cur_word = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (r_addr == ADDR_WIDTH'(k)) w_cur_word = regs_i[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         r_be <= '0;
    else if (w_accept) r_be <= be_i;
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    assign w_merged[gi*8 +: 8] = r_be[gi] ? r_wdata[gi*8 +: 8] : w_cur_word[gi*8 +: 8];
  end
`else
  logic w_unused_be;
  assign w_unused_be = ^be_i;

  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    assign w_merged[gi*8 +: 8] = r_wdata[gi*8 +: 8];
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_shadow <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_we     <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_we     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_err   <= !w_in_range;
            r_rdata <= '0;
            if (!w_in_range || !we_i) begin
              r_state  <= RESP;
              r_rvalid <= 1'b1;
              if (w_in_range) r_rdata <= w_rd_word;
            end else begin
              r_state <= MERGE;
            end
          end
        end
        MERGE: begin
          // Whole array is refreshed from the PMU so the bulk write is coherent.
          for (int k = 0; k < N_REGS; k++) begin
            r_shadow[k] <= (r_addr == ADDR_WIDTH'(k)) ? w_merged : regs_i[k];
          end
          r_state <= COMMIT;
          r_we    <= 1'b1;
        end
        COMMIT: begin
          r_state  <= RESP;
          r_rvalid <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A reset landing on a strobe cycle must not let the strobe escape.
  assign wrapper_we_o = r_we && !rst_i;
  assign rvalid_o     = r_rvalid && !rst_i;
  assign rdata_o      = r_rdata;
  assign err_o        = r_err;
  assign regs_o       = r_shadow;

endmodule
